// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;
`else
    localparam int UART_FRAME_BITS = 10;
`endif
    localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_rx_core_if.sv
// Receiver-side signal bundle: serial line, baud-generator handshake and byte output.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_core_if #(
    parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
);
    logic                 rs232_rx;
    logic                 clk_bps;
    logic                 bps_start;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_int;
    logic                 rx_valid;
    logic                 frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        input  rs232_rx, clk_bps,
        output bps_start, rx_data, rx_int, rx_valid, frame_err
`ifdef UART_RX_PARITY_EN
        , output parity_err
`endif
    );

    modport slave (
        output rs232_rx, clk_bps,
        input  bps_start, rx_data, rx_int, rx_valid, frame_err
`ifdef UART_RX_PARITY_EN
        , input parity_err
`endif
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous line with a registered falling-edge strobe.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic neg_edge
);

    // sync_q[0] is the first stage, sync_q[SYNC_STAGES-1] the last
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   neg_edge_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= {SYNC_STAGES{UART_IDLE_LVL}};
            neg_edge_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], din};
            neg_edge_q <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
        end
    end

    assign dout     = sync_q[SYNC_STAGES-1];
    assign neg_edge = neg_edge_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver driven by an external mid-bit baud strobe (bps_start/clk_bps).
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SYNC_STAGES = 3,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_core_if.master  bus
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

    logic line;
    logic neg_edge;

    uart_state_e state_q, state_d;
    logic                 busy_q;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`else
    logic                 unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .din      (bus.rs232_rx),
        .dout     (line),
        .neg_edge (neg_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= (state_d != IDLE);
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // IDLE only listens for a start edge; every other state advances on the baud strobe
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (neg_edge) state_d = START;
            START:  if (bus.clk_bps) state_d = line ? IDLE : DATA;
            DATA: begin
                if (bus.clk_bps && (cnt_q == CNT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
            PARITY: if (bus.clk_bps) state_d = STOP;
            STOP:   if (bus.clk_bps) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
            end
            START: if (bus.clk_bps && !line) cnt_d = '0;
            DATA: begin
                if (bus.clk_bps) begin
                    shreg_d = {line, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (bus.clk_bps) par_bad_d = (line != ((^shreg_q) ^ PARITY_ODD));
`endif
            STOP: begin
                if (bus.clk_bps) begin
                    // a low stop bit masks any parity result
                    if (!line) begin
                        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shreg_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.bps_start  = busy_q;
    assign bus.rx_int     = busy_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver: deserialises an 8N1 RS232 line into a byte.
- Pairs with the existing transmitter and shares the same external baud generator (bps_start / clk_bps handshake).
- rx_int stays high for the whole reception. Its falling edge marks a completed frame, which the transmitter uses to echo the byte back.
- rx_data holds the last good byte until the next good frame.

Parameters:
- DATA_BITS, 8, payload bits per frame (LSB first).
- SYNC_STAGES, 3, flops on rs232_rx before edge detect (min 2).
- PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined (0 = even, 1 = odd). Ignored otherwise.

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous reset, active high
- rs232_rx  in  1  asynchronous serial line, idle high
- clk_bps  in  1  one-cycle pulse at mid-bit from baud generator; first pulse half a bit after bps_start rises
- bps_start  out  1  high while a frame is being received; enables baud generator
- rx_data  out  DATA_BITS  last correctly received byte
- rx_int  out  1  high from start-edge detect until frame end
- rx_valid  out  1  one-cycle pulse, rx_data updated
- frame_err  out  1  one-cycle pulse, stop bit sampled low
- parity_err  out  1  present only with UART_RX_PARITY_EN; one-cycle pulse on parity mismatch

Behaviour:
- All state and outputs are registered and update on the posedge clk. Reset is sampled on the clock only.
- Reset values:
  - state = IDLE
  - all sync flops = 1
  - shift register and bit counter = 0
  - rx_data = 0
  - bps_start, rx_int, rx_valid, frame_err, parity_err = 0
- Reset mid-frame aborts the frame: no pulses, rx_data cleared.
- Synchroniser: rs232_rx passes through SYNC_STAGES flops. Sampled line = last stage. neg_edge = previous-to-last stage low AND last stage high, i.e. a 1→0 transition, registered.
- IDLE:
  - clk_bps is ignored.
  - On neg_edge: go to START, and set bps_start = 1 and rx_int = 1 on the same edge.
- START, on clk_bps:
  - Line low: go to DATA, bit counter = 0.
  - Line high (glitch): go to IDLE, clear bps_start and rx_int, no pulses.
- DATA, on clk_bps:
  - Shift: shreg <= {line, shreg[DATA_BITS-1:1]}; counter += 1.
  - After the DATA_BITS-th sample, go to STOP (or PARITY when the macro is defined).
- STOP, on clk_bps:
  - Line high: rx_data <= shreg and pulse rx_valid.
  - Line low: pulse frame_err; rx_data unchanged.
  - In both cases go to IDLE and clear bps_start and rx_int on the same edge as the pulse.
  - So the rx_int falling edge coincides with rx_valid or frame_err.
- neg_edge outside IDLE is ignored.
- After a frame ends, a line still low (break) does not retrigger. A fresh high→low transition is required.
- Simultaneous neg_edge and clk_bps in IDLE: neg_edge wins, clk_bps is ignored.
- Bit counter width is $clog2(DATA_BITS+1). It never wraps in legal operation and returns to 0 in IDLE.
- Latency: rx_valid asserts one clk after the mid-stop-bit clk_bps pulse is sampled, i.e. about 9.5 bit times after the start edge plus SYNC_STAGES+1 clocks.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled on clk_bps.
  - Expected parity = ^shreg XOR PARITY_ODD.
  - A mismatch is remembered until STOP. At STOP, a mismatch with the line high gives a parity_err pulse, no rx_valid, and rx_data unchanged.
  - A low stop bit gives frame_err only; frame_err takes precedence and parity_err stays low.
  - The parity_err port exists.
- Undefined: no PARITY state, no parity_err port, pure 8N1.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP}
  - UART_DATA_BITS = 8
  - UART_FRAME_BITS = 10 (11 with parity)
  - idle line level constant
- Sub-module uart_rx_sync: parameter SYNC_STAGES; ports clk, rst, din, dout, neg_edge. It is reusable by other line inputs.

Test Plan:
- Receive 0x55 at 9600 baud (bench models the baud generator, 5208 clk/bit) -> bps_start and rx_int rise; after stop, one rx_valid pulse with rx_data = 0x55; rx_int falls on the same edge; frame_err = 0.
- Back-to-back 0xA3 then 0x0F (second start bit immediately after the first stop bit) -> two rx_valid pulses, rx_data 0xA3 then 0x0F, rx_int low for at least one cycle between frames.
- Line low for 1/4 bit then high -> at the first clk_bps, return to IDLE; bps_start and rx_int drop; no rx_valid or frame_err; rx_data keeps its prior value.
- After a good 0x12, send 0xFF with stop bit 0 -> frame_err one-cycle pulse, rx_valid = 0, rx_data stays 0x12, bps_start = 0.
- Assert rst for 2 cycles in the middle of DATA of 0xC3 -> all outputs 0 and rx_data = 0 on the next edge; the following frame 0x3C is received correctly.
- UART_RX_PARITY_EN, PARITY_ODD = 0: send 0x07 with parity bit 0 -> parity_err pulse, no rx_valid. Resend with parity bit 1 -> rx_valid, rx_data = 0x07.
